panda_risc_v_trap_csr: RTL

Machine-mode trap CSR file for the Panda RISC-V core. It is the responder side of the commit unit's trap interface. It captures trap entry (mepc/mcause/mtval, mstatus stacking) and trap return (MRET unstacking). It supplies interrupt enables, the trap vector address and the MRET return address back to commit. It also serves the EXU CSR read/modify instructions.

---
 rtl/panda_risc_v_csr_pkg.sv | 53 +++++
 rtl/panda_risc_v_trap_csr_if.sv | 37 +++
 rtl/panda_risc_v_csr_upd.sv | 24 ++
 rtl/panda_risc_v_trap_csr.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_csr_pkg.sv
// -----------------------------------------------------------------------------
// panda_risc_v_csr_pkg
// Shared definitions for the machine-mode CSR file and the commit unit:
// CSR addresses, update type codes, mstatus/mie/mip bit positions and the
// interrupt / exception cause codes.
// -----------------------------------------------------------------------------
package panda_risc_v_csr_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   // CSR update type carried with each EXU CSR instruction
   typedef enum logic [1:0] {
      UPD_NONE  = 2'b00,
      UPD_WRITE = 2'b01,
      UPD_SET   = 2'b10,
      UPD_CLR   = 2'b11
   } csr_upd_e;

   // mstatus fields
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

   // mie / mip fields (same positions in both registers)
   localparam int MIX_MS_BIT = 3;
   localparam int MIX_MT_BIT = 7;
   localparam int MIX_ME_BIT = 11;

   // Interrupt cause codes
   localparam logic [7:0] INTR_CAUSE_MSI = 8'd3;
   localparam logic [7:0] INTR_CAUSE_MTI = 8'd7;
   localparam logic [7:0] INTR_CAUSE_MEI = 8'd11;

   // Exception cause codes
   localparam logic [7:0] EXPT_CAUSE_INST_MISALIGN  = 8'd0;
   localparam logic [7:0] EXPT_CAUSE_INST_ACCESS    = 8'd1;
   localparam logic [7:0] EXPT_CAUSE_ILLEGAL_INST   = 8'd2;
   localparam logic [7:0] EXPT_CAUSE_BREAKPOINT     = 8'd3;
   localparam logic [7:0] EXPT_CAUSE_LOAD_MISALIGN  = 8'd4;
   localparam logic [7:0] EXPT_CAUSE_LOAD_ACCESS    = 8'd5;
   localparam logic [7:0] EXPT_CAUSE_STORE_MISALIGN = 8'd6;
   localparam logic [7:0] EXPT_CAUSE_STORE_ACCESS   = 8'd7;
   localparam logic [7:0] EXPT_CAUSE_ECALL_M        = 8'd11;

endpackage

// File: rtl/panda_risc_v_trap_csr_if.sv
// -----------------------------------------------------------------------------
// panda_risc_v_trap_csr_if
// Trap interface between the commit unit (master) and the trap CSR file
// (slave).
// Handshake: itr_expt_enter and itr_expt_ret are single-cycle strobes with no
// ready; the CSR file accepts them every cycle. The commit unit samples
// itr_expt_vec_baseaddr and mepc_ret_addr combinationally in the same cycle it
// raises a strobe. The enable bits are plain register levels.
// -----------------------------------------------------------------------------
interface panda_risc_v_trap_csr_if;
   logic        itr_expt_enter;
   logic        itr_expt_is_intr;
   logic [7:0]  itr_expt_cause;
   logic [31:0] itr_expt_ret_addr;
   logic [31:0] itr_expt_val;
   logic [31:0] itr_expt_vec_baseaddr;
   logic        itr_expt_ret;
   logic [31:0] mepc_ret_addr;
   logic        mstatus_mie_v;
   logic        mie_msie_v;
   logic        mie_mtie_v;
   logic        mie_meie_v;

   modport master (
      output itr_expt_enter, itr_expt_is_intr, itr_expt_cause,
             itr_expt_ret_addr, itr_expt_val, itr_expt_ret,
      input  itr_expt_vec_baseaddr, mepc_ret_addr,
             mstatus_mie_v, mie_msie_v, mie_mtie_v, mie_meie_v
   );

   modport slave (
      input  itr_expt_enter, itr_expt_is_intr, itr_expt_cause,
             itr_expt_ret_addr, itr_expt_val, itr_expt_ret,
      output itr_expt_vec_baseaddr, mepc_ret_addr,
             mstatus_mie_v, mie_msie_v, mie_mtie_v, mie_meie_v
   );
endinterface

// File: rtl/panda_risc_v_csr_upd.sv
// -----------------------------------------------------------------------------
// panda_risc_v_csr_upd
// Combinational write/set/clear merge for one CSR.
// Ports: old_v (current value), mask_v (write data or bit mask),
//        upd_type (update type), new_v (merged value).
// -----------------------------------------------------------------------------
module panda_risc_v_csr_upd
   import panda_risc_v_csr_pkg::*;
(
   input  logic [31:0] old_v,
   input  logic [31:0] mask_v,
   input  csr_upd_e    upd_type,
   output logic [31:0] new_v
);
   always_comb begin
      new_v = old_v;
      case (upd_type)
         UPD_WRITE: new_v = mask_v;
         UPD_SET:   new_v = old_v | mask_v;
         UPD_CLR:   new_v = old_v & ~mask_v;
         default:   new_v = old_v;
      endcase
   end
endmodule

// File: rtl/panda_risc_v_trap_csr.sv
// -----------------------------------------------------------------------------
// panda_risc_v_trap_csr
// Machine-mode trap CSR file: mstatus, mie, mip, mtvec, mscratch, mepc,
// mcause, mtval. Captures trap entry, unstacks on MRET, serves EXU CSR
// read/modify and feeds enables / vector / return address back to commit.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   csr_rw_*               EXU CSR access (combinational read, strobed update)
//   sw/tmr/ext_itr_req     raw interrupt levels shown in mip
//   trap                   trap interface (slave side)
// Build option: define PANDA_RISC_V_MTVEC_VECTORED_EN to enable vectored
// mtvec mode; otherwise the block is direct mode only.
// -----------------------------------------------------------------------------
module panda_risc_v_trap_csr
   import panda_risc_v_csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST_V = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic [11:0] csr_rw_addr,
   input  logic [1:0]  csr_rw_upd_type,
   input  logic [31:0] csr_rw_upd_mask_v,
   input  logic        csr_rw_valid,
   output logic [31:0] csr_rw_rdata,
   input  logic        sw_itr_req,
   input  logic        tmr_itr_req,
   input  logic        ext_itr_req,
   panda_risc_v_trap_csr_if.slave trap
);
   logic        mie_q, mpie_q;
   logic        msie_q, mtie_q, meie_q;
   logic [29:0] mtvec_base_q;
   logic [29:0] mepc_q;
   logic        mcause_intr_q;
   logic [7:0]  mcause_code_q;
   logic [31:0] mtval_q, mscratch_q;
   logic [1:0]  mtvec_mode;
`ifdef PANDA_RISC_V_MTVEC_VECTORED_EN
   // Only modes 00/01 are legal, so one bit holds the mode.
   logic        mtvec_mode_q;
   assign mtvec_mode = {1'b0, mtvec_mode_q};
`else
   assign mtvec_mode = 2'b00;
`endif

   // Architectural views of each register
   logic [31:0] mstatus_rd, mie_rd, mip_rd, mtvec_rd, mepc_rd, mcause_rd;
   assign mstatus_rd = {19'd0, MSTATUS_MPP_M, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
   assign mie_rd     = {20'd0, meie_q, 3'd0, mtie_q, 3'd0, msie_q, 3'd0};
   assign mip_rd     = {20'd0, ext_itr_req, 3'd0, tmr_itr_req, 3'd0, sw_itr_req, 3'd0};
   assign mtvec_rd   = {mtvec_base_q, mtvec_mode};
   assign mepc_rd    = {mepc_q, 2'b00};
   assign mcause_rd  = {mcause_intr_q, 23'd0, mcause_code_q};

   always_comb begin
      csr_rw_rdata = 32'd0;
      case (csr_rw_addr)
         CSR_MSTATUS:  csr_rw_rdata = mstatus_rd;
         CSR_MIE:      csr_rw_rdata = mie_rd;
         CSR_MIP:      csr_rw_rdata = mip_rd;
         CSR_MTVEC:    csr_rw_rdata = mtvec_rd;
         CSR_MSCRATCH: csr_rw_rdata = mscratch_q;
         CSR_MEPC:     csr_rw_rdata = mepc_rd;
         CSR_MCAUSE:   csr_rw_rdata = mcause_rd;
         CSR_MTVAL:    csr_rw_rdata = mtval_q;
         default:      csr_rw_rdata = 32'd0;
      endcase
   end

   // Merge logic, one instance per writable CSR
   csr_upd_e    upd_type;
   logic [31:0] mstatus_new, mie_new, mtvec_new, mepc_new, mcause_new, mtval_new, mscratch_new;
   assign upd_type = csr_upd_e'(csr_rw_upd_type);

   panda_risc_v_csr_upd u_upd_mstatus  (.old_v(mstatus_rd), .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mstatus_new));
   panda_risc_v_csr_upd u_upd_mie      (.old_v(mie_rd),     .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mie_new));
   panda_risc_v_csr_upd u_upd_mtvec    (.old_v(mtvec_rd),   .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mtvec_new));
   panda_risc_v_csr_upd u_upd_mepc     (.old_v(mepc_rd),    .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mepc_new));
   panda_risc_v_csr_upd u_upd_mcause   (.old_v(mcause_rd),  .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mcause_new));
   panda_risc_v_csr_upd u_upd_mtval    (.old_v(mtval_q),    .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mtval_new));
   panda_risc_v_csr_upd u_upd_mscratch (.old_v(mscratch_q), .mask_v(csr_rw_upd_mask_v), .upd_type(upd_type), .new_v(mscratch_new));

   // Trap entry/return own mstatus/mepc/mcause/mtval; a coincident CSR
   // update to those four is dropped, updates to the rest still land.
   logic trap_evt, wr_hit;
   logic we_mstatus, we_mie, we_mtvec, we_mepc, we_mcause, we_mtval, we_mscratch;
   assign trap_evt    = trap.itr_expt_enter | trap.itr_expt_ret;
   assign wr_hit      = csr_rw_valid & (upd_type != UPD_NONE);
   assign we_mstatus  = wr_hit & ~trap_evt & (csr_rw_addr == CSR_MSTATUS);
   assign we_mepc     = wr_hit & ~trap_evt & (csr_rw_addr == CSR_MEPC);
   assign we_mcause   = wr_hit & ~trap_evt & (csr_rw_addr == CSR_MCAUSE);
   assign we_mtval    = wr_hit & ~trap_evt & (csr_rw_addr == CSR_MTVAL);
   assign we_mie      = wr_hit & (csr_rw_addr == CSR_MIE);
   assign we_mtvec    = wr_hit & (csr_rw_addr == CSR_MTVEC);
   assign we_mscratch = wr_hit & (csr_rw_addr == CSR_MSCRATCH);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         msie_q        <= 1'b0;
         mtie_q        <= 1'b0;
         meie_q        <= 1'b0;
         mtvec_base_q  <= MTVEC_RST_V[31:2];
`ifdef PANDA_RISC_V_MTVEC_VECTORED_EN
         mtvec_mode_q  <= 1'b0;
`endif
         mepc_q        <= 30'd0;
         mcause_intr_q <= 1'b0;
         mcause_code_q <= 8'd0;
         mtval_q       <= 32'd0;
         mscratch_q    <= 32'd0;
      end else begin
         // enter wins over ret
         if (trap.itr_expt_enter) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
         end else if (trap.itr_expt_ret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end else if (we_mstatus) begin
            mie_q  <= mstatus_new[MSTATUS_MIE_BIT];
            mpie_q <= mstatus_new[MSTATUS_MPIE_BIT];
         end

         if (we_mie) begin
            msie_q <= mie_new[MIX_MS_BIT];
            mtie_q <= mie_new[MIX_MT_BIT];
            meie_q <= mie_new[MIX_ME_BIT];
         end

         if (we_mtvec) begin
            mtvec_base_q <= mtvec_new[31:2];
`ifdef PANDA_RISC_V_MTVEC_VECTORED_EN
            // MODE 2'b1x is reserved: keep the current mode
            if (!mtvec_new[1])
               mtvec_mode_q <= mtvec_new[0];
`endif
         end

         if (trap.itr_expt_enter) begin
            mepc_q        <= trap.itr_expt_ret_addr[31:2];
            mcause_intr_q <= trap.itr_expt_is_intr;
            mcause_code_q <= trap.itr_expt_cause;
            mtval_q       <= trap.itr_expt_val;
         end else begin
            if (we_mepc)
               mepc_q <= mepc_new[31:2];
            if (we_mcause) begin
               mcause_intr_q <= mcause_new[31];
               mcause_code_q <= mcause_new[7:0];
            end
            if (we_mtval)
               mtval_q <= mtval_new;
         end

         if (we_mscratch)
            mscratch_q <= mscratch_new;
      end
   end

   assign trap.mstatus_mie_v  = mie_q;
   assign trap.mie_msie_v     = msie_q;
   assign trap.mie_mtie_v     = mtie_q;
   assign trap.mie_meie_v     = meie_q;
   assign trap.mepc_ret_addr  = mepc_rd;

`ifdef PANDA_RISC_V_MTVEC_VECTORED_EN
   // Vectored mode offsets interrupts by cause*4; exceptions use the base.
   assign trap.itr_expt_vec_baseaddr = (mtvec_mode_q && trap.itr_expt_is_intr) ?
      ({mtvec_base_q, 2'b00} + {22'd0, trap.itr_expt_cause, 2'b00}) :
      {mtvec_base_q, 2'b00};
`else
   assign trap.itr_expt_vec_baseaddr = {mtvec_base_q, 2'b00};
   logic mtvec_unused;
   assign mtvec_unused = ^mtvec_new[1:0];
`endif

   // Merge-output bits that have no storage behind them
   logic upd_unused;
   assign upd_unused = ^{mstatus_new[31:8], mstatus_new[6:4], mstatus_new[2:0],
                         mie_new[31:12], mie_new[10:8], mie_new[6:4], mie_new[2:0],
                         mepc_new[1:0], mcause_new[30:8], trap.itr_expt_ret_addr[1:0]};
endmodule
